// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: frames one word per handshake and
// drives load/shift strobes for a downstream PISO register.
module uart_tx_ctrl #(
    parameter int DATA_BITS  = 8,
    parameter int CLK_DIV    = 434,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [DATA_BITS-1:0]                        tx_data,
    input  logic                                        tx_valid,
    output logic                                        tx_ready,
    output logic [DATA_BITS+PARITY_EN+STOP_BITS:0]      piso_data,
    output logic                                        piso_load,
    output logic                                        piso_enable,
    output logic                                        busy,
    output logic                                        tx_done
);

    localparam int FRAME_W = 1 + DATA_BITS + PARITY_EN + STOP_BITS;
    localparam int BW      = $clog2(FRAME_W + 1);
    localparam int DW      = $clog2(CLK_DIV);

    localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_W);
    localparam logic [DW-1:0] LAST_CNT = DW'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        DONE
    } state_t;

    state_t               state;
    state_t               state_n;
    logic [DW-1:0]        baud_cnt;
    logic [DW-1:0]        baud_n;
    logic [BW-1:0]        bit_cnt;
    logic [BW-1:0]        bit_n;
    logic [FRAME_W-1:0]   frame_n;
    logic [FRAME_W-1:0]   data_n;
    logic                 parity;
    logic                 tick;

    assign tick     = (baud_cnt == LAST_CNT);
    assign tx_ready = (state == IDLE);
    assign busy     = ~tx_ready;

    // Assemble the frame: start bit at LSB, data, parity, stop bits on top.
    always_comb begin
        parity     = (^tx_data) ^ (PARITY_ODD != 0);
        frame_n    = '1;
        frame_n[0] = 1'b0;
        frame_n[DATA_BITS:1] = tx_data;
        if (PARITY_EN != 0) begin
            frame_n[DATA_BITS+1] = parity;
        end
    end

    // Next-state logic and one-cycle strobes.
    always_comb begin
        state_n     = state;
        baud_n      = baud_cnt;
        bit_n       = bit_cnt;
        data_n      = piso_data;
        piso_load   = 1'b0;
        piso_enable = 1'b0;
        tx_done     = 1'b0;
        unique case (state)
            IDLE: begin
                if (tx_valid) begin
                    data_n  = frame_n;
                    state_n = LOAD;
                end
            end
            LOAD: begin
                piso_load = 1'b1;
                baud_n    = '0;
                bit_n     = '0;
                state_n   = SHIFT;
            end
            SHIFT: begin
                baud_n = tick ? '0 : baud_cnt + 1'b1;
                if (tick) begin
                    // The extra tick after the last shift gives the
                    // final stop bit its full baud period on the line.
                    if (bit_cnt == LAST_BIT) begin
                        state_n = DONE;
                    end else begin
                        piso_enable = 1'b1;
                        bit_n       = bit_cnt + 1'b1;
                    end
                end
            end
            DONE: begin
                tx_done = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // State, counters and captured frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            piso_data <= '1;
        end else begin
            state     <= state_n;
            baud_cnt  <= baud_n;
            bit_cnt   <= bit_n;
            piso_data <= data_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl over several parameter sets,
// with random traffic against a bit-list frame model.
module tb_uart_tx_ctrl;

    localparam int N = 4;

    function automatic int cfg_db(int g);
        case (g)
            0: return 8;
            1: return 8;
            2: return 8;
            default: return 9;
        endcase
    endfunction

    function automatic int cfg_cd(int g);
        case (g)
            0: return 4;
            1: return 4;
            2: return 3;
            default: return 2;
        endcase
    endfunction

    function automatic int cfg_pe(int g);
        case (g)
            2: return 0;
            default: return 1;
        endcase
    endfunction

    function automatic int cfg_po(int g);
        case (g)
            1: return 1;
            3: return 1;
            default: return 0;
        endcase
    endfunction

    function automatic int cfg_sb(int g);
        case (g)
            2: return 2;
            3: return 2;
            default: return 1;
        endcase
    endfunction

    function automatic int cfg_fw(int g);
        return 1 + cfg_db(g) + cfg_pe(g) + cfg_sb(g);
    endfunction

    // Frame as a list of line bits, first bit sent at position 0.
    function automatic logic [15:0] model_frame(int g, logic [8:0] d);
        logic [15:0] v;
        int pos;
        int ones;
        v    = 16'h0;
        pos  = 1;
        ones = 0;
        for (int i = 0; i < cfg_db(g); i++) begin
            if (d[i]) begin
                v[pos] = 1'b1;
                ones++;
            end
            pos++;
        end
        if (cfg_pe(g) != 0) begin
            if (((ones % 2) ^ cfg_po(g)) != 0) v[pos] = 1'b1;
            pos++;
        end
        for (int s = 0; s < cfg_sb(g); s++) begin
            v[pos] = 1'b1;
            pos++;
        end
        return v;
    endfunction

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    logic [8:0]  txd [N];
    logic        txv [N];
    logic        rdy [N];
    logic        bz  [N];
    logic        ld  [N];
    logic        en  [N];
    logic        dn  [N];
    logic [15:0] pd  [N];

    for (genvar g = 0; g < N; g++) begin : gi
        localparam int DB = cfg_db(g);
        localparam int FW = cfg_fw(g);
        logic [FW-1:0] pdw;
        logic r, b, l, e, d;
        uart_tx_ctrl #(
            .DATA_BITS (DB),
            .CLK_DIV   (cfg_cd(g)),
            .PARITY_EN (cfg_pe(g)),
            .PARITY_ODD(cfg_po(g)),
            .STOP_BITS (cfg_sb(g))
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .tx_data    (txd[g][DB-1:0]),
            .tx_valid   (txv[g]),
            .tx_ready   (r),
            .piso_data  (pdw),
            .piso_load  (l),
            .piso_enable(e),
            .busy       (b),
            .tx_done    (d)
        );
        assign rdy[g] = r;
        assign bz[g]  = b;
        assign ld[g]  = l;
        assign en[g]  = e;
        assign dn[g]  = d;
        assign pd[g]  = 16'(pdw);
    end

    typedef struct {
        logic [15:0] frame;
        int          hs;
    } exp_t;

    exp_t q [N][$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   n_push [N];
    bit   active [N];
    bit   chk_rdy [N];
    int   k [N];
    exp_t cur [N];

    task automatic chk(string nm, int g, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d cycle %0d: got 0x%0h, want 0x%0h",
                     nm, g, cyc, act, exp);
        end
    endtask

    // Stimulus side: record expected frame whenever a handshake is set up.
    always @(negedge clk) begin
        exp_t e;
        #3;
        if (!rst) begin
            for (int g = 0; g < N; g++) begin
                if (txv[g] && rdy[g]) begin
                    e.frame = model_frame(g, txd[g]);
                    e.hs    = cyc;
                    q[g].push_back(e);
                    n_push[g]++;
                end
            end
        end
    end

    // Monitor: pop on load, then check strobe timing and frame stability.
    always @(negedge clk) begin
        for (int g = 0; g < N; g++) begin
            if (rst) begin
                q[g].delete();
                active[g]  = 1'b0;
                chk_rdy[g] = 1'b0;
            end else begin
                if (chk_rdy[g]) begin
                    chk("ready_after_done", g, 32'(rdy[g]), 1);
                    chk_rdy[g] = 1'b0;
                end
                if (ld[g]) begin
                    chk("load_enable_overlap", g, 32'(en[g]), 0);
                    chk("queue_depth_at_load", g, q[g].size(), 1);
                    if (q[g].size() > 0) begin
                        cur[g] = q[g].pop_front();
                        chk("load_time", g, cyc, cur[g].hs + 1);
                        chk("frame", g, 32'(pd[g]), 32'(cur[g].frame));
                        chk("busy_in_load", g, {rdy[g], bz[g]}, 2'b01);
                        active[g] = 1'b1;
                        k[g]      = 0;
                    end
                end else if (active[g]) begin
                    if (en[g]) begin
                        k[g]++;
                        chk("enable_time", g, cyc,
                            cur[g].hs + 1 + k[g] * cfg_cd(g));
                        chk("frame_hold", g, 32'(pd[g]), 32'(cur[g].frame));
                        chk("busy_in_shift", g, {rdy[g], bz[g]}, 2'b01);
                    end
                    if (dn[g]) begin
                        chk("enable_count", g, k[g], cfg_fw(g));
                        chk("done_time", g, cyc,
                            cur[g].hs + 2 + (cfg_fw(g) + 1) * cfg_cd(g));
                        chk("enable_done_overlap", g, 32'(en[g]), 0);
                        active[g]  = 1'b0;
                        chk_rdy[g] = 1'b1;
                    end else if (cyc > cur[g].hs + 4
                                 + (cfg_fw(g) + 1) * cfg_cd(g)) begin
                        chk("done_timeout", g, cyc,
                            cur[g].hs + 2 + (cfg_fw(g) + 1) * cfg_cd(g));
                        active[g] = 1'b0;
                    end
                end else begin
                    chk("idle_strobes", g, {en[g], dn[g]}, 2'b00);
                end
            end
        end
    end

    task automatic check_reset(string tag);
        logic [15:0] ones;
        for (int g = 0; g < N; g++) begin
            ones = 16'((32'd1 << cfg_fw(g)) - 32'd1);
            chk({tag, "_ready"}, g, 32'(rdy[g]), 1);
            chk({tag, "_busy"}, g, 32'(bz[g]), 0);
            chk({tag, "_strobes"}, g, {ld[g], en[g], dn[g]}, 3'b000);
            chk({tag, "_piso_data"}, g, 32'(pd[g]), 32'(ones));
        end
    endtask

    task automatic wait_idle(int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            #1;
            ok = 1'b1;
            for (int g = 0; g < N; g++) begin
                if (!rdy[g] || active[g] || chk_rdy[g] || q[g].size() != 0)
                    ok = 1'b0;
            end
        end
        if (!ok) begin
            n_chk++;
            n_fail++;
            $display("FAIL idle_wait: not idle after %0d cycles", budget);
        end
    endtask

    task automatic send(int g, logic [8:0] d);
        txv[g] = 1'b1;
        txd[g] = d;
    endtask

    task automatic drop_all();
        @(negedge clk);
        #1;
        for (int g = 0; g < N; g++) txv[g] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        for (int g = 0; g < N; g++) begin
            txv[g]     = 1'b0;
            txd[g]     = '0;
            n_push[g]  = 0;
            active[g]  = 1'b0;
            chk_rdy[g] = 1'b0;
            k[g]       = 0;
        end
        repeat (3) @(posedge clk);
        #2;
        check_reset("reset");
        @(posedge clk);
        #2;
        rst = 1'b0;
        wait_idle(5);

        send(0, 9'h0A5);
        send(1, 9'h0A5);
        send(2, 9'h080);
        send(3, 9'h1A5);
        drop_all();
        wait_idle(200);

        send(0, 9'h001);
        send(1, 9'h001);
        send(2, 9'h0FF);
        send(3, 9'h100);
        drop_all();
        wait_idle(200);

        p0 = n_push[0];
        send(0, 9'h0A5);
        @(negedge clk);
        #1;
        txd[0] = 9'h03C;
        repeat ((cfg_fw(0) + 1) * cfg_cd(0) + 6) @(negedge clk);
        #1;
        txv[0] = 1'b0;
        wait_idle(200);
        chk("held_valid_accepts", 0, n_push[0] - p0, 2);

        for (int g = 0; g < N; g++) send(g, 9'($urandom));
        drop_all();
        repeat (20) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset("midframe_reset");
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        wait_idle(10);
        for (int g = 0; g < N; g++) send(g, 9'($urandom));
        drop_all();
        wait_idle(200);

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            #1;
            for (int g = 0; g < N; g++) begin
                txv[g] = ($urandom_range(0, 2) == 0);
                txd[g] = 9'($urandom);
            end
        end
        drop_all();
        wait_idle(200);

        for (int g = 0; g < N; g++) begin
            chk("final_queue_empty", g, q[g].size(), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
- Transmit-side controller for the UART. It sits directly upstream of the PISO shift register.
- Accepts one data word per valid/ready handshake and builds the serial frame: start bit, data LSB-first, optional parity, stop bit(s).
- Presents the frame as a parallel word, pulses the PISO load strobe, then issues one shift-enable per baud period from an internal clock divider.
- Serial_Out of the PISO is the TX line; this block never drives the line itself.

Parameters:
- DATA_BITS, 8: data word width (5..9).
- CLK_DIV, 434: clk cycles per baud period (50 MHz / 115200); must be >= 2.
- PARITY_EN, 1: 1 = append parity bit, 0 = no parity bit.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity; ignored when PARITY_EN = 0.
- STOP_BITS, 1: number of stop bits (1 or 2).
- FRAME_W (derived, localparam): 1 + DATA_BITS + PARITY_EN + STOP_BITS (11 at defaults).

Ports:
- clk, input, 1: system clock; all state changes on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- tx_data, input, DATA_BITS: word to send; sampled on handshake.
- tx_valid, input, 1: producer has a word.
- tx_ready, output, 1: controller can accept a word.
- piso_data, output, FRAME_W: framed word, driven to PISO Parallel_In.
- piso_load, output, 1: one-cycle load strobe, driven to PISO load.
- piso_enable, output, 1: one-cycle shift strobe per baud tick, driven to PISO enable.
- busy, output, 1: frame in progress.
- tx_done, output, 1: one-cycle pulse at end of frame.

Behaviour:
- Reset values: state IDLE, baud_cnt = 0, bit_cnt = 0, piso_data = all ones, piso_load = 0, piso_enable = 0, tx_done = 0, tx_ready = 1, busy = 0. Reset is asynchronous and takes effect mid-frame; no partial frame resumes afterwards.
- tx_ready = (state == IDLE); busy = ~tx_ready.
- States: IDLE -> LOAD -> SHIFT -> DONE -> IDLE.
- IDLE: when tx_valid && tx_ready at a rising edge, register piso_data = {STOP_BITS ones, parity bit (if PARITY_EN), tx_data, 1'b0} (LSB = start bit), then go to LOAD.
  - Even parity bit = ^tx_data; odd parity bit = ~^tx_data.
  - Without a handshake, stay in IDLE.
- LOAD: lasts 1 cycle; piso_load = 1; baud_cnt and bit_cnt cleared; go to SHIFT.
- SHIFT:
  - baud_cnt counts 0..CLK_DIV-1 and wraps; tick = (baud_cnt == CLK_DIV-1).
  - On a tick with bit_cnt < FRAME_W: piso_enable = 1 for that cycle, bit_cnt + 1.
  - On a tick with bit_cnt == FRAME_W: no enable; go to DONE. This gives the last stop bit a full baud period.
- DONE: lasts 1 cycle; tx_done = 1; go to IDLE.
- Timing, with the handshake edge = cycle 0:
  - piso_load high in cycle 1.
  - Enables in cycles 1 + k·CLK_DIV for k = 1..FRAME_W.
  - tx_done in cycle 2 + (FRAME_W+1)·CLK_DIV; tx_ready high the following cycle.
- piso_load and piso_enable are never high in the same cycle.
- piso_data holds stable from capture until the next accepted word.
- tx_valid while busy is ignored. tx_data changes while busy have no effect. No back-to-back overlap: minimum one IDLE cycle between frames.

Test Plan:
- Reset while idle: hold rst, release -> tx_ready = 1, busy = 0, piso_data = all ones (0x7FF at defaults), piso_load, piso_enable and tx_done all 0.
- Defaults, CLK_DIV = 4, send 0xA5 (even parity) -> piso_data = 0x54A; piso_load in cycle 1; 11 enables at cycles 5, 9, ..., 45; tx_done in cycle 50; tx_ready = 1 in cycle 51. With a PISO model attached, line reads 0,1,0,1,0,0,1,0,1,0,1.
- PARITY_ODD = 1, send 0xA5 -> piso_data = 0x74A. Send 0x01 with even parity -> piso_data = 0x602.
- During a frame, tx_valid = 1 with tx_data = 0x3C -> tx_ready stays 0; the frame under way is unchanged; 0x3C is accepted only after tx_done.
- Assert rst at cycle 20 of a frame -> all outputs at reset values immediately; next accepted word yields a complete, correct frame.
- PARITY_EN = 0, STOP_BITS = 2, send 0x80 -> FRAME_W = 11, piso_data = 0x700, 11 enables per frame.
